pwm_fader: RTL and testbench

- Upstream duty-cycle source for the pwm block.
- Its duty output drives pwm.in directly.
- Accepts "fade to target" commands over a valid/ready handshake and ramps duty toward the target in programmable steps at a programmable rate.
- Optional breathe mode bounces duty between 0 and the target until a new command arrives.

---
 rtl/pwm_fader.sv | 66 ++++++
 tb/tb_pwm_fader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pwm_fader.sv
// pwm_fader: ramps a pwm duty value toward a commanded target, with optional 0<->target breathing.
module pwm_fader #(
  parameter int WIDTH = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_target,
  input  logic [WIDTH-1:0]     cmd_step,
  input  logic [DIV_WIDTH-1:0] cmd_rate,
  input  logic                 cmd_breathe,
  output logic [WIDTH-1:0]     duty,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, RAMP, BREATHE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] tgt, stp, goal, duty_n;
  logic [DIV_WIDTH-1:0] rate, cnt;
  logic [WIDTH:0] up, dn;
  logic accept, tick, hit, eb, same;
  assign cmd_ready = state != RAMP;
  assign busy = state != IDLE;
  assign accept = cmd_valid & cmd_ready;
  assign tick = busy && cnt == rate;
  assign eb = cmd_breathe && cmd_target != '0;
  assign same = cmd_target == duty;
  assign up = {1'b0, duty} + {1'b0, stp};
  assign dn = {1'b0, duty} - {1'b0, stp};
  assign hit = duty_n == goal;
  // goal is the current end point: target for fades, alternating target/0 while breathing
  always_comb begin
    duty_n = goal > duty ? (up > {1'b0, goal} ? goal : up[WIDTH-1:0])
                         : ((dn[WIDTH] || dn[WIDTH-1:0] < goal) ? goal : dn[WIDTH-1:0]);
    state_n = accept ? (eb ? BREATHE : (same ? IDLE : RAMP))
                     : ((tick && hit && state == RAMP) ? IDLE : state);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      duty <= '0;
      tgt <= '0;
      stp <= '0;
      goal <= '0;
      rate <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= accept ? (!eb && same) : (tick && hit && state == RAMP);
      if (accept) begin
        tgt <= cmd_target;
        stp <= cmd_step == '0 ? WIDTH'(1) : cmd_step;
        rate <= cmd_rate;
        cnt <= '0;
        goal <= (eb && same) ? '0 : cmd_target;
      end else if (busy) begin
        cnt <= tick ? '0 : cnt + DIV_WIDTH'(1);
        if (tick) duty <= duty_n;
        if (tick && hit && state == BREATHE) goal <= goal == '0 ? tgt : '0;
      end
    end
  end
endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: randomized scoreboard bench; expected duty/done events are queued per command.
module tb_pwm_fader;
  localparam int W = 8;
  localparam int D = 16;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_breathe = 0;
  logic [W-1:0] cmd_target = '0, cmd_step = '0;
  logic [D-1:0] cmd_rate = '0;
  logic cmd_ready, busy, done;
  logic [W-1:0] duty;
  typedef struct {int cyc; int d; int dn;} ev_t;
  ev_t q[$];
  int total = 0, bad = 0, cyc = 0, md = 0, mend = 0;

  pwm_fader #(.WIDTH(W), .DIV_WIDTH(D)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_rate(cmd_rate),
    .cmd_breathe(cmd_breathe), .duty(duty), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d want %0d", nm, cyc, got, exp);
    end
  endtask

  function automatic void push(input int c, input int d, input int dn);
    ev_t e;
    e.cyc = c;
    e.d = d;
    e.dn = dn;
    q.push_back(e);
  endfunction

  // Reference: tick k of a command accepted at edge a lands at edge a+k*(rate+1); ticks at or after lim are lost.
  task automatic plan(input int t, input int s, input int r, input bit b, input int a, input int lim);
    int g, c;
    bit eb;
    eb = b && t != 0;
    s = s == 0 ? 1 : s;
    if (!eb && t == md) begin
      push(a, md, 1);
      mend = a;
      return;
    end
    g = (eb && t == md) ? 0 : t;
    for (int k = 1; k < 100000; k++) begin
      c = a + k * (r + 1);
      if (c >= lim) break;
      if (g > md) md = (md + s < g) ? md + s : g;
      else md = (md - s > g) ? md - s : g;
      push(c, md, (!eb && md == g) ? 1 : 0);
      if (md == g) begin
        if (!eb) begin
          mend = c;
          break;
        end
        g = (g == 0) ? t : 0;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge just before the next command may be issued.
  task automatic run(input int t, input int s, input int r, input bit b, input int span);
    int a, stop;
    bit eb;
    eb = b && t != 0;
    a = cyc + 1;
    cmd_target = W'(t);
    cmd_step = W'(s);
    cmd_rate = D'(r);
    cmd_breathe = b;
    cmd_valid = 1;
    plan(t, s, r, b, a, eb ? a + span : 1 << 30);
    stop = eb ? a + span - 1 : mend;
    @(negedge clk);
    cmd_valid = 0;
    while (cyc < stop) begin
      chk("ready_during", cmd_ready, eb ? 1 : 0);
      chk("busy_during", busy, 1);
      @(negedge clk);
    end
    if (!eb) begin
      chk("ready_after", cmd_ready, 1);
      chk("busy_after", busy, 0);
    end
  endtask

  initial begin : monitor
    ev_t e;
    logic [W-1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst && (duty != prev || done)) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event at cyc %0d: duty=%0d done=%0d with nothing expected", cyc, duty, done);
        end else begin
          e = q.pop_front();
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_duty", duty, e.d);
          chk("ev_done", done, e.dn);
        end
      end
      prev = duty;
    end
  end

  initial begin : stim
    int a;
    repeat (3) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    rst = 0;
    @(negedge clk);
    run(10, 3, 1, 0, 0);
    run(0, 4, 0, 0, 0);
    run(0, 0, 0, 0, 0);
    run(4, 2, 0, 1, 7);
    run(1, 0, 0, 0, 0);
    run(250, 255, 0, 0, 0);
    run(255, 200, 0, 0, 0);
    run(0, 0, 2, 1, 0);
    a = cyc + 1;
    cmd_target = 8'd200;
    cmd_step = 8'd1;
    cmd_rate = 16'd3;
    cmd_breathe = 0;
    cmd_valid = 1;
    plan(200, 1, 3, 0, a, 1 << 30);
    @(negedge clk);
    cmd_valid = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_duty", duty, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    q.delete();
    md = 0;
    rst = 0;
    @(negedge clk);
    chk("postrst_duty", duty, 0);
    chk("postrst_done", done, 0);
    for (int i = 0; i < 25; i++) begin
      int t, s, r, b, span;
      t = $urandom_range(0, 255);
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
      r = $urandom_range(0, 3);
      b = $urandom_range(0, 1);
      span = $urandom_range(3, 40);
      run(t, s, r, b[0], span);
    end
    run(0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
